// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-FF synchronizer, consecutive-sample debouncer,
// registered press/release pulses and hold auto-repeat.
module button_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam bit          RPT_EN  = (REPEAT_DELAY != 0);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] db_state;
  logic [DB_W-1:0]  db_cnt    [N_BTN];
  rpt_state_t       rpt_state [N_BTN];
  logic [RPT_W-1:0] rpt_cnt   [N_BTN];

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] rpt_fire;
  logic [N_BTN-1:0] press_nxt;

  // db_state is the accepted level; btn_level is its registered copy, so the
  // level change and its pulse appear together one cycle after acceptance.
  always_comb begin
    rise     = db_state & ~btn_level;
    fall     = ~db_state & btn_level;
    rpt_fire = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      case (rpt_state[i])
        RPT_HOLD:   rpt_fire[i] = RPT_EN && (rpt_cnt[i] == DELAY_LAST);
        RPT_REPEAT: rpt_fire[i] = (rpt_cnt[i] == PERIOD_LAST);
        default:    rpt_fire[i] = 1'b0;
      endcase
    end
    press_nxt = rise | (rpt_fire & ~fall);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      db_state    <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        db_cnt[i]    <= '0;
        rpt_state[i] <= RPT_IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      btn_level   <= db_state;
      btn_press   <= press_nxt;
      btn_release <= fall;
      any_press   <= |press_nxt;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (sync2[i] == db_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_state[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end

        if (fall[i]) begin
          rpt_state[i] <= RPT_IDLE;
          rpt_cnt[i]   <= '0;
        end else if (rise[i]) begin
          rpt_state[i] <= RPT_HOLD;
          rpt_cnt[i]   <= '0;
        end else begin
          case (rpt_state[i])
            RPT_HOLD: begin
              if (!RPT_EN) begin
                rpt_cnt[i] <= '0;
              end else if (rpt_fire[i]) begin
                rpt_state[i] <= RPT_REPEAT;
                rpt_cnt[i]   <= '0;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (rpt_fire[i]) rpt_cnt[i] <= '0;
              else             rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
            end
            default: rpt_cnt[i] <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, multi-cycle corner sequences and
// random stimulus against a sliding-window reference model.
module tb_button_conditioner;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       any_press;

  int errors = 0;
  int checks = 0;
  int edge_n = -1;
  string phase = "init";

  button_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // Reference model: level follows the last D raw samples once they all agree,
  // seen two pipeline stages plus one output stage later; repeats by elapsed time.
  logic [3:0]  win[$];
  logic [3:0]  m_level, m_press, m_release;
  logic        m_any;
  int unsigned held [4];

  function automatic void model_clear();
    win.delete();
    repeat (D + 2) win.push_back(4'b0000);
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    m_any     = 1'b0;
    foreach (held[i]) held[i] = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] raw);
    logic [3:0]  s;
    logic [3:0]  nl;
    int unsigned ones;
    win.push_back(raw);
    while (win.size() > D + 3) void'(win.pop_front());
    nl        = m_level;
    m_press   = '0;
    m_release = '0;
    for (int i = 0; i < 4; i++) begin
      ones = 0;
      for (int k = 0; k < D; k++) begin
        s = win[k];
        ones += s[i];
      end
      if (ones == D && !m_level[i]) nl[i] = 1'b1;
      else if (ones == 0 && m_level[i]) nl[i] = 1'b0;
      if (nl[i] && !m_level[i]) begin
        m_press[i] = 1'b1;
        held[i]    = 0;
      end else if (!nl[i] && m_level[i]) begin
        m_release[i] = 1'b1;
      end else if (nl[i]) begin
        held[i]++;
        if (RD != 0 && held[i] >= RD && (held[i] - RD) % RP == 0) m_press[i] = 1'b1;
      end
    end
    m_level = nl;
    m_any   = |m_press;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%s edge %0d]: got %0h expected %0h", name, phase, edge_n, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {btn_level, btn_press, btn_release, any_press};
  endfunction

  // Drives raw at the falling edge, advances the model at the rising edge, checks 1 later.
  task automatic step(input logic [3:0] raw);
    @(negedge clk);
    btn_raw = raw;
    @(posedge clk);
    edge_n++;
    model_edge(raw);
    #1;
    check("model", 32'(outs()), 32'({m_level, m_press, m_release, m_any}));
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges.
  task automatic hit_reset();
    #1 reset = 1'b1;
    #1 check("reset_clear", 32'(outs()), 32'd0);
    model_clear();
  endtask

  task automatic drop_reset();
    #1 reset = 1'b0;
    edge_n = -1;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int   np, nr, pe, re;
  int   exp_edges[$];
  int   got_edges[$];
  logic [3:0] rnd;

  initial begin
    // Hold up from edge 0: accepted at edge 6, single press, no release.
    for (int e = 0; e < 10; e++) begin
      v.rst   = 1'b0;
      v.raw   = 4'b1000;
      v.level = (e >= 6) ? 4'b1000 : 4'b0000;
      v.press = (e == 6) ? 4'b1000 : 4'b0000;
      v.rel   = 4'b0000;
      v.any   = (e == 6);
      vecs.push_back(v);
    end
    // Three-cycle glitch on down: nothing ever propagates.
    for (int e = 0; e < 11; e++) begin
      v.rst   = (e == 0);
      v.raw   = (e < 3) ? 4'b0010 : 4'b0000;
      v.level = 4'b0000;
      v.press = 4'b0000;
      v.rel   = 4'b0000;
      v.any   = 1'b0;
      vecs.push_back(v);
    end

    reset   = 1'b1;
    btn_raw = 4'b0000;
    model_clear();
    @(posedge clk);
    #1 check("reset_state", 32'(outs()), 32'd0);
    drop_reset();

    phase = "table";
    foreach (vecs[n]) begin
      if (vecs[n].rst) begin
        hit_reset();
        drop_reset();
      end
      step(vecs[n].raw);
      check("vec", 32'(outs()),
            32'({vecs[n].level, vecs[n].press, vecs[n].rel, vecs[n].any}));
    end

    phase = "toggle";
    hit_reset();
    drop_reset();
    np = 0;
    pe = -1;
    for (int k = 0; k < 52; k++) begin
      step((k >= 40 || (k % 4) < 2) ? 4'b0001 : 4'b0000);
      if (btn_press[0]) begin
        np++;
        pe = edge_n;
      end
    end
    check("toggle_press_count", 32'(np), 32'd1);
    check("toggle_press_edge", 32'(pe), 32'd46);

    phase = "repeat";
    hit_reset();
    drop_reset();
    got_edges.delete();
    exp_edges.delete();
    exp_edges.push_back(6);
    for (int t = 6 + RD; t <= 36; t += RP) exp_edges.push_back(t);
    for (int k = 0; k < 37; k++) begin
      step(4'b1000);
      if (btn_press[3]) got_edges.push_back(edge_n);
    end
    check("repeat_count", 32'(got_edges.size()), 32'(exp_edges.size()));
    foreach (exp_edges[j])
      if (j < got_edges.size()) check("repeat_edge", 32'(got_edges[j]), 32'(exp_edges[j]));

    phase = "hold_release";
    hit_reset();
    drop_reset();
    np = 0; nr = 0; pe = -1; re = -1;
    for (int k = 0; k < 20; k++) begin
      step((k < 5) ? 4'b1000 : 4'b0000);
      if (btn_press[3])   begin np++; pe = edge_n; end
      if (btn_release[3]) begin nr++; re = edge_n; end
    end
    check("hold_press_count", 32'(np), 32'd1);
    check("hold_press_edge", 32'(pe), 32'd6);
    check("hold_release_count", 32'(nr), 32'd1);
    check("hold_release_edge", 32'(re), 32'd11);

    phase = "reset_mid";
    hit_reset();
    drop_reset();
    for (int k = 0; k < 3; k++) step(4'b1111);
    hit_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_held", 32'(outs()), 32'd0);
    drop_reset();
    for (int k = 0; k < 20; k++) step(4'b1111);
    check("pre_reset_press", 32'({btn_level, btn_press}), 32'h0ff);
    hit_reset();
    btn_raw = 4'b1010;
    repeat (2) @(posedge clk);
    #1 check("reset_held2", 32'(outs()), 32'd0);
    drop_reset();
    for (int k = 0; k < 10; k++) begin
      step(4'b1010);
      check("simul_press", 32'({btn_press, any_press}),
            (edge_n == 6) ? 32'b10101 : 32'd0);
    end

    phase = "random";
    hit_reset();
    drop_reset();
    rnd = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 6) == 0) rnd[i] = ~rnd[i];
      step(rnd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
